// File: rtl/inst_queue.sv
// Prefetch FIFO of instruction/PC pairs feeding an instruction register stage,
// with flush-to-NOP and fixed 16-bit decoder field slices of the IR.
module inst_queue #(
   parameter int unsigned    IW       = 16,
   parameter int unsigned    AW       = 16,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [IW-1:0]  NOP_INST = 16'h4300
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IW-1:0]                inst_in,
   input  logic [AW-1:0]                pc_in,
   input  logic                         advance,
   input  logic                         flush,
   output logic [IW-1:0]                inst_out,
   output logic [AW-1:0]                pc_out,
   output logic                         inst_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic [4:0]                   immed5,
   output logic [6:0]                   immed7,
   output logic [7:0]                   immed8,
   output logic [10:0]                  immed11,
   output logic [2:0]                   Rs0,
   output logic [2:0]                   Rs1,
   output logic [2:0]                   Rs2,
   output logic [2:0]                   Rs3,
   output logic [2:0]                   Rd0,
   output logic [2:0]                   Rd1
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned EW = IW + AW;

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [IW-1:0] inst_q, inst_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          valid_q, valid_d;
   logic          push_fire, pop_fire;
   logic [EW-1:0] head;

   // Ready never anticipates a same-cycle pop, so a full queue always refuses.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign push_fire = in_valid && in_ready && !flush;
   assign pop_fire  = advance && (count_q != '0) && !flush;
   assign head      = mem_q[rd_ptr_q];

   // Data entries carry no reset; they are only read while occupied.
   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem_q[wr_ptr_q] <= {inst_in, pc_in};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      inst_d   = inst_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
         inst_d   = NOP_INST;
         valid_d  = 1'b0;
      end else begin
         if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            inst_d   = head[EW-1:AW];
            pc_d     = head[AW-1:0];
            valid_d  = 1'b1;
         end else if (advance) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
         end
         count_d = count_q + CW'(push_fire) - CW'(pop_fire);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         inst_q   <= NOP_INST;
         pc_q     <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         inst_q   <= inst_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
      end
   end

   assign inst_out   = inst_q;
   assign pc_out     = pc_q;
   assign inst_valid = valid_q;
   assign count      = count_q;

   // Decoder field slices, no added latency.
   assign immed5  = inst_q[10:6];
   assign immed7  = inst_q[6:0];
   assign immed8  = inst_q[7:0];
   assign immed11 = inst_q[10:0];
   assign Rs0     = inst_q[2:0];
   assign Rs1     = inst_q[5:3];
   assign Rs2     = inst_q[8:6];
   assign Rs3     = inst_q[10:8];
   assign Rd0     = inst_q[2:0];
   assign Rd1     = inst_q[10:8];

endmodule
